// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// log2() returns the number of bits needed to hold its argument.
package fifo_arb_pkg;

   typedef enum logic [0:0] {ST_IDLE, ST_XFER} arb_state_t;

   localparam int unsigned PKT_CNT_WIDTH = 16;

   function automatic int unsigned log2(input int unsigned value);
      int unsigned n;
      n = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((value >> i) != 0) n = i + 1;
      end
      return n;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after i_last_id, modulo N.
// The request vector is doubled so the wrap-around search becomes a plain priority encode.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = (log2(N - 1) < 1) ? 1 : log2(N - 1)
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_last_id,
   output logic          o_any,
   output logic [IW-1:0] o_pick_id
);

   logic [2*N-1:0] w_dbl;
   logic [2*N-1:0] w_mask;
   logic [2*N-1:0] w_cand;

   always_comb begin
      w_dbl = {i_req, i_req};
      w_mask = '0;
      for (int unsigned i = 0; i < 2 * N; i++) begin
         w_mask[i] = (i > 32'(i_last_id)) && (i <= 32'(i_last_id) + N);
      end
      w_cand = w_dbl & w_mask;
      // Descending scan so the lowest candidate position wins.
      o_pick_id = '0;
      for (int unsigned i = 2 * N; i > 0; i--) begin
         if (w_cand[i-1]) o_pick_id = (i - 1 >= N) ? IW'(i - 1 - N) : IW'(i - 1);
      end
   end

   assign o_any = |i_req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-granular round-robin arbiter sharing one FIFO write port among NUM_REQ requesters.
// Throttles on full (and optionally almost-full at grant time); forces release after MAX_PKT_LEN beats.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ       = 4,
   parameter int unsigned WIDTH         = 32,
   parameter int unsigned MAX_PKT_LEN   = 256,
   parameter string       ALM_FULL_GATE = "TRUE",
   parameter int unsigned ID_WIDTH      = (log2(NUM_REQ - 1) < 1) ? 1 : log2(NUM_REQ - 1)
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic [NUM_REQ-1:0]       i_req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] i_req_data,
   input  logic [NUM_REQ-1:0]       i_req_last,
   output logic [NUM_REQ-1:0]       o_req_ready,
   output logic                     o_fifo_wr_en,
   output logic [WIDTH-1:0]         o_fifo_wr_data,
   input  logic                     i_fifo_full,
   input  logic                     i_fifo_almost_full,
   output logic                     o_grant_valid,
   output logic [ID_WIDTH-1:0]      o_grant_id,
   output logic [PKT_CNT_WIDTH-1:0] o_pkt_cnt,
   output logic                     o_err_trunc
);

   localparam bit                     GATE_EN   = (ALM_FULL_GATE == "TRUE");
   localparam logic [15:0]            LAST_BEAT = 16'(MAX_PKT_LEN - 1);

   arb_state_t                 r_state,       w_nxt_state;
   logic [ID_WIDTH-1:0]        r_grant_id,    w_nxt_grant_id;
   logic                       r_grant_valid, w_nxt_grant_valid;
   logic [ID_WIDTH-1:0]        r_last_id,     w_nxt_last_id;
   logic [15:0]                r_beat_cnt,    w_nxt_beat_cnt;
   logic [PKT_CNT_WIDTH-1:0]   r_pkt_cnt,     w_nxt_pkt_cnt;
   logic                       r_err_trunc,   w_nxt_err_trunc;

   logic                       w_any;
   logic [ID_WIDTH-1:0]        w_pick;
   logic                       w_accept;

   rr_pick #(
      .N  (NUM_REQ),
      .IW (ID_WIDTH)
   ) u_pick (
      .i_req     (i_req_valid),
      .i_last_id (r_last_id),
      .o_any     (w_any),
      .o_pick_id (w_pick)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= ST_IDLE;
         r_grant_id    <= '0;
         r_grant_valid <= 1'b0;
         r_last_id     <= ID_WIDTH'(NUM_REQ - 1);
         r_beat_cnt    <= '0;
         r_pkt_cnt     <= '0;
         r_err_trunc   <= 1'b0;
      end else begin
         r_state       <= w_nxt_state;
         r_grant_id    <= w_nxt_grant_id;
         r_grant_valid <= w_nxt_grant_valid;
         r_last_id     <= w_nxt_last_id;
         r_beat_cnt    <= w_nxt_beat_cnt;
         r_pkt_cnt     <= w_nxt_pkt_cnt;
         r_err_trunc   <= w_nxt_err_trunc;
      end
   end

   always_comb begin
      w_nxt_state       = r_state;
      w_nxt_grant_id    = r_grant_id;
      w_nxt_grant_valid = r_grant_valid;
      w_nxt_last_id     = r_last_id;
      w_nxt_beat_cnt    = r_beat_cnt;
      w_nxt_pkt_cnt     = r_pkt_cnt;
      w_nxt_err_trunc   = 1'b0;
      o_req_ready       = '0;
      o_fifo_wr_en      = 1'b0;
      o_fifo_wr_data    = '0;
      w_accept          = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_any && (!GATE_EN || !i_fifo_almost_full)) begin
               w_nxt_grant_id    = w_pick;
               w_nxt_grant_valid = 1'b1;
               w_nxt_beat_cnt    = '0;
               w_nxt_state       = ST_XFER;
            end
         end
         ST_XFER: begin
            o_req_ready[r_grant_id] = ~i_fifo_full;
            o_fifo_wr_data          = i_req_data[r_grant_id*WIDTH +: WIDTH];
            w_accept                = i_req_valid[r_grant_id] & ~i_fifo_full;
            o_fifo_wr_en            = w_accept;
            if (w_accept) begin
               w_nxt_beat_cnt = r_beat_cnt + 16'd1;
               // A last beat always counts as a packet, even when it lands on the length limit.
               if (i_req_last[r_grant_id] || (r_beat_cnt == LAST_BEAT)) begin
                  w_nxt_state       = ST_IDLE;
                  w_nxt_grant_valid = 1'b0;
                  w_nxt_last_id     = r_grant_id;
                  if (i_req_last[r_grant_id]) w_nxt_pkt_cnt   = r_pkt_cnt + PKT_CNT_WIDTH'(1);
                  else                        w_nxt_err_trunc = 1'b1;
               end
            end
         end
         default: w_nxt_state = ST_IDLE;
      endcase
   end

   assign o_grant_valid = r_grant_valid;
   assign o_grant_id    = r_grant_id;
   assign o_pkt_cnt     = r_pkt_cnt;
   assign o_err_trunc   = r_err_trunc;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomised scoreboard bench for fifo_wr_arbiter: stimulus pushes per-requester expected beats,
// a negedge monitor applies the arbitration rules and pops/compares each FIFO write.
module tb_fifo_wr_arbiter;

   localparam int N      = 4;
   localparam int W      = 32;
   localparam int MAXLEN = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [N-1:0]     req_valid = '0;
   logic [N*W-1:0]   req_data = '0;
   logic [N-1:0]     req_last = '0;
   logic [N-1:0]     req_ready;
   logic             wr_en;
   logic [W-1:0]     wr_data;
   logic             fifo_full = 1'b0;
   logic             fifo_af = 1'b0;
   logic             grant_valid;
   logic [1:0]       grant_id;
   logic [15:0]      pkt_cnt;
   logic             err_trunc;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(
      .NUM_REQ       (N),
      .WIDTH         (W),
      .MAX_PKT_LEN   (MAXLEN),
      .ALM_FULL_GATE ("TRUE")
   ) dut (
      .i_clk              (clk),
      .i_rst_n            (rst_n),
      .i_req_valid        (req_valid),
      .i_req_data         (req_data),
      .i_req_last         (req_last),
      .o_req_ready        (req_ready),
      .o_fifo_wr_en       (wr_en),
      .o_fifo_wr_data     (wr_data),
      .i_fifo_full        (fifo_full),
      .i_fifo_almost_full (fifo_af),
      .o_grant_valid      (grant_valid),
      .o_grant_id         (grant_id),
      .o_pkt_cnt          (pkt_cnt),
      .o_err_trunc        (err_trunc)
   );

   typedef struct {
      logic [W-1:0] data;
      logic         last;
   } beat_t;

   beat_t       exp_q [N][$];
   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;
   int          left [N];
   logic [23:0] seq [N];
   logic [N-1:0] acc = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic bit pct(input int p);
      return int'($urandom_range(99)) < p;
   endfunction

   // One stimulus cycle: sample handshakes at negedge, drive new inputs just after posedge.
   task automatic stim_cycle(input int p_full, input int p_af, input int p_start,
                             input int lo, input int hi, input int p_bub, input bit allow_new);
      beat_t b;
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      fifo_full = pct(p_full);
      fifo_af   = pct(p_af);
      for (int k = 0; k < N; k++) begin
         if (req_valid[k] && !acc[k]) continue;
         if (req_valid[k]) begin
            left[k]--;
            req_valid[k] = 1'b0;
         end
         if (left[k] == 0 && allow_new && pct(p_start))
            left[k] = int'($urandom_range(hi - lo)) + lo;
         if (left[k] > 0 && !pct(p_bub)) begin
            b.data = {8'(k), seq[k]};
            b.last = (left[k] == 1);
            seq[k]++;
            req_valid[k]         = 1'b1;
            req_data[k*W +: W]   = b.data;
            req_last[k]          = b.last;
            exp_q[k].push_back(b);
         end
      end
   endtask

   task automatic clear_stim();
      req_valid = '0;
      req_last  = '0;
      fifo_full = 1'b0;
      fifo_af   = 1'b0;
      acc       = '0;
      for (int k = 0; k < N; k++) begin
         left[k] = 0;
         exp_q[k].delete();
      end
   endtask

   // Monitor: reference rules of the arbiter, applied once per cycle at the negedge.
   initial begin : monitor
      int        m_last;
      bit        m_busy;
      int        m_gid;
      int        m_beats;
      bit        m_err;
      bit        found;
      logic [15:0] m_pkt;
      logic [N-1:0] exp_ready;
      bit        exp_wr;
      beat_t     b;
      m_last = N - 1; m_busy = 0; m_gid = 0; m_beats = 0; m_err = 0; m_pkt = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk("rst_grant_valid", 32'(grant_valid), 0);
            chk("rst_grant_id", 32'(grant_id), 0);
            chk("rst_pkt_cnt", 32'(pkt_cnt), 0);
            chk("rst_wr_en", 32'(wr_en), 0);
            chk("rst_ready", 32'(req_ready), 0);
            m_last = N - 1; m_busy = 0; m_err = 0; m_pkt = '0;
            continue;
         end
         chk("pkt_cnt", 32'(pkt_cnt), 32'(m_pkt));
         chk("err_trunc", 32'(err_trunc), 32'(m_err));
         chk("grant_valid", 32'(grant_valid), 32'(m_busy));
         m_err = 0;
         if (!m_busy) begin
            chk("idle_ready", 32'(req_ready), 0);
            chk("idle_wr_en", 32'(wr_en), 0);
            if (req_valid != '0 && !fifo_af) begin
               found = 0;
               for (int s = 1; s <= N; s++) begin
                  if (!found && req_valid[(m_last + s) % N]) begin
                     m_gid = (m_last + s) % N;
                     found = 1;
                  end
               end
               m_busy = 1;
               m_beats = 0;
            end
         end else begin
            exp_ready = fifo_full ? '0 : N'(1 << m_gid);
            exp_wr    = req_valid[m_gid] && !fifo_full;
            chk("grant_id", 32'(grant_id), 32'(m_gid));
            chk("ready", 32'(req_ready), 32'(exp_ready));
            chk("wr_en", 32'(wr_en), 32'(exp_wr));
            if (exp_wr) begin
               if (exp_q[m_gid].size() == 0) begin
                  chk("wr_unexpected", 1, 0);
               end else begin
                  b = exp_q[m_gid].pop_front();
                  chk("wr_data", wr_data, b.data);
                  m_beats++;
                  if (b.last) begin
                     m_pkt++;
                     m_busy = 0;
                     m_last = m_gid;
                  end else if (m_beats == MAXLEN) begin
                     m_err  = 1;
                     m_busy = 0;
                     m_last = m_gid;
                  end
               end
            end
         end
      end
   end

   initial begin : stimulus
      int  waited;
      bit  idle;
      for (int k = 0; k < N; k++) begin
         left[k] = 0;
         seq[k]  = '0;
      end
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;

      // Continuous 2-beat packets from every requester: pure rotation, no throttling.
      repeat (200) stim_cycle(0, 0, 100, 2, 2, 0, 1'b1);
      // Random mix with full stalls, almost-full gating, bubbles and truncation.
      repeat (1500) stim_cycle(20, 20, 30, 1, 12, 10, 1'b1);

      // Asynchronous reset while a beat is being written.
      waited = 0;
      while (!(grant_valid && wr_en) && waited < 200) begin
         stim_cycle(0, 0, 50, 3, 10, 0, 1'b1);
         waited++;
      end
      chk("rst_precond", 32'(grant_valid && wr_en), 1);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("async_rst_wr_en", 32'(wr_en), 0);
      chk("async_rst_grant", 32'(grant_valid), 0);
      clear_stim();
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;

      repeat (1000) stim_cycle(10, 10, 40, 1, 12, 5, 1'b1);

      // Drain: finish open packets with the FIFO never full.
      waited = 0;
      idle = 0;
      while (!idle && waited < 500) begin
         stim_cycle(0, 0, 0, 1, 1, 0, 1'b0);
         waited++;
         idle = (req_valid == '0) && !grant_valid;
         for (int k = 0; k < N; k++) if (left[k] != 0 || exp_q[k].size() != 0) idle = 0;
      end
      chk("drain_done", 32'(idle), 1);
      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
